// File: rtl/zlib_stored_pkg.sv
// Shared constants, state encoding and small helpers for the stored-block zlib packer.
package zlib_stored_pkg;

  localparam logic [7:0]  ZLIB_CMF     = 8'h78;
  localparam logic [7:0]  ZLIB_FLG     = 8'h01;
  localparam logic [16:0] ADLER_MOD    = 17'd65521;
  localparam logic [1:0]  BTYPE_STORED = 2'b00;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_BHDR,
    ST_LEN0,
    ST_LEN1,
    ST_NLEN0,
    ST_NLEN1,
    ST_DATA,
    ST_ADL0,
    ST_ADL1,
    ST_ADL2,
    ST_ADL3
  } state_e;

  // Deflate block header byte: BFINAL in bit 0, BTYPE in bits 2:1.
  function automatic logic [7:0] bhdrByte(input logic isFinal);
    return {5'b00000, BTYPE_STORED, isFinal};
  endfunction

endpackage

// File: rtl/zlib_stored_adler.sv
// Adler-32 running checksum, one byte per cycle; only built when ZLIB_WRAP_EN is defined.
`ifdef ZLIB_WRAP_EN
module adler32_acc
  import zlib_stored_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        clr_i,
  input  logic        val_i,
  input  logic [7:0]  dat_i,
  output logic [15:0] a_o,
  output logic [15:0] b_o
);

  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [16:0] aSum, aMod, bSum, bMod;

  // Both sums stay below 2*ADLER_MOD, so a single conditional subtract reduces them.
  always_comb begin
    aSum = {1'b0, a_q} + {9'b0, dat_i};
    aMod = (aSum >= ADLER_MOD) ? aSum - ADLER_MOD : aSum;
    bSum = {1'b0, b_q} + aMod;
    bMod = (bSum >= ADLER_MOD) ? bSum - ADLER_MOD : bSum;
    a_d  = a_q;
    b_d  = b_q;
    if (clr_i) begin
      a_d = 16'd1;
      b_d = 16'd0;
    end else if (val_i) begin
      a_d = aMod[15:0];
      b_d = bMod[15:0];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_q <= 16'd1;
      b_q <= 16'd0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  assign a_o = a_q;
  assign b_o = b_q;

endmodule
`endif

// File: rtl/zlib_stored.sv
// Wraps a payload byte stream in stored deflate blocks; with ZLIB_WRAP_EN defined it adds
// the zlib header and Adler-32 trailer, otherwise it emits a raw deflate stream.
module zlib_stored
  import zlib_stored_pkg::*;
#(
  parameter int unsigned BLK_MAX = 65535,
  parameter int unsigned LEN_WD  = 24
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [LEN_WD-1:0] cfg_len_i,
  input  logic              start_i,
  output logic              done_o,
  input  logic              in_val_i,
  input  logic [7:0]        in_dat_i,
  output logic              in_rdy_o,
  output logic              out_val_o,
  output logic [7:0]        out_dat_o,
  input  logic              out_rdy_i
);

`ifdef ZLIB_WRAP_EN
  localparam state_e FIRST_ST = ST_HDR0;
  localparam state_e END_ST   = ST_ADL0;
`else
  localparam state_e FIRST_ST = ST_BHDR;
  localparam state_e END_ST   = ST_IDLE;
`endif

  state_e            state_q, state_d, effState;
  logic [LEN_WD-1:0] remain_q, remain_d, effRem;
  logic [15:0]       blkCnt_q, blkCnt_d, blkSize;
  logic              outVal_q, outVal_d;
  logic [7:0]        outDat_q, outDat_d;
  logic              lastPend_q, lastPend_d;
  logic              done_q, done_d;
  logic              adv, inRdy, blkFinal;

`ifdef ZLIB_WRAP_EN
  logic              accClr, accVal;
  logic [15:0]       adlA, adlB;

  adler32_acc uAdler (
    .clk   (clk),
    .rstn  (rstn),
    .clr_i (accClr),
    .val_i (accVal),
    .dat_i (in_dat_i),
    .a_o   (adlA),
    .b_o   (adlB)
  );
`endif

  // The output register may take a new byte when empty or being drained this cycle.
  assign adv = !outVal_q || out_rdy_i;

  always_comb begin
    state_d    = state_q;
    remain_d   = remain_q;
    blkCnt_d   = blkCnt_q;
    outVal_d   = outVal_q;
    outDat_d   = outDat_q;
    lastPend_d = lastPend_q;
    done_d     = 1'b0;
    inRdy      = 1'b0;
    effState   = state_q;
    effRem     = remain_q;
`ifdef ZLIB_WRAP_EN
    accClr     = 1'b0;
    accVal     = 1'b0;
`endif
    if (lastPend_q && outVal_q && out_rdy_i) begin
      lastPend_d = 1'b0;
      done_d     = 1'b1;
    end
    if (adv) outVal_d = 1'b0;
    // A start folds the first stream byte into the same cycle so it is valid right after.
    if (state_q == ST_IDLE && start_i) begin
      effState = FIRST_ST;
      effRem   = cfg_len_i;
      remain_d = cfg_len_i;
`ifdef ZLIB_WRAP_EN
      accClr   = 1'b1;
`endif
    end
    blkFinal = (effRem <= LEN_WD'(BLK_MAX));
    blkSize  = blkFinal ? effRem[15:0] : 16'(BLK_MAX);
    state_d  = effState;
    case (effState)
`ifdef ZLIB_WRAP_EN
      ST_HDR0: if (adv) begin outVal_d = 1'b1; outDat_d = ZLIB_CMF; state_d = ST_HDR1; end
      ST_HDR1: if (adv) begin outVal_d = 1'b1; outDat_d = ZLIB_FLG; state_d = ST_BHDR; end
      ST_ADL0: if (adv) begin outVal_d = 1'b1; outDat_d = adlB[15:8]; state_d = ST_ADL1; end
      ST_ADL1: if (adv) begin outVal_d = 1'b1; outDat_d = adlB[7:0]; state_d = ST_ADL2; end
      ST_ADL2: if (adv) begin outVal_d = 1'b1; outDat_d = adlA[15:8]; state_d = ST_ADL3; end
      ST_ADL3: if (adv) begin outVal_d = 1'b1; outDat_d = adlA[7:0]; state_d = ST_IDLE; end
`endif
      ST_BHDR: if (adv) begin
        outVal_d = 1'b1;
        outDat_d = bhdrByte(blkFinal);
        blkCnt_d = blkSize;
        state_d  = ST_LEN0;
      end
      ST_LEN0:  if (adv) begin outVal_d = 1'b1; outDat_d = blkCnt_q[7:0]; state_d = ST_LEN1; end
      ST_LEN1:  if (adv) begin outVal_d = 1'b1; outDat_d = blkCnt_q[15:8]; state_d = ST_NLEN0; end
      ST_NLEN0: if (adv) begin outVal_d = 1'b1; outDat_d = ~blkCnt_q[7:0]; state_d = ST_NLEN1; end
      ST_NLEN1: if (adv) begin
        outVal_d = 1'b1;
        outDat_d = ~blkCnt_q[15:8];
        state_d  = (blkCnt_q == 16'd0) ? END_ST : ST_DATA;
      end
      ST_DATA: begin
        inRdy = adv;
        if (adv && in_val_i) begin
          outVal_d = 1'b1;
          outDat_d = in_dat_i;
          remain_d = remain_q - LEN_WD'(1);
          blkCnt_d = blkCnt_q - 16'd1;
`ifdef ZLIB_WRAP_EN
          accVal   = 1'b1;
`endif
          if (blkCnt_q == 16'd1) state_d = (remain_q == LEN_WD'(1)) ? END_ST : ST_BHDR;
        end
      end
      default: ;
    endcase
    // Any return to IDLE coincides with loading the final stream byte.
    if (effState != ST_IDLE && state_d == ST_IDLE) lastPend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      remain_q   <= '0;
      blkCnt_q   <= '0;
      outVal_q   <= 1'b0;
      outDat_q   <= '0;
      lastPend_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      remain_q   <= remain_d;
      blkCnt_q   <= blkCnt_d;
      outVal_q   <= outVal_d;
      outDat_q   <= outDat_d;
      lastPend_q <= lastPend_d;
      done_q     <= done_d;
    end
  end

  assign in_rdy_o  = inRdy;
  assign out_val_o = outVal_q;
  assign out_dat_o = outDat_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_zlib_stored.sv
// Bench for zlib_stored with a small block size; follows ZLIB_WRAP_EN to pick the expected framing.
module tb_zlib_stored;

  localparam int BLK = 4;
  localparam int LW  = 24;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [LW-1:0] cfg_len_i = '0;
  logic          start_i = 1'b0;
  logic          done_o;
  logic          in_val_i = 1'b0;
  logic [7:0]    in_dat_i = 8'h00;
  logic          in_rdy_o;
  logic          out_val_o;
  logic [7:0]    out_dat_o;
  logic          out_rdy_i = 1'b1;

  always #5 clk = ~clk;

  zlib_stored #(.BLK_MAX(BLK), .LEN_WD(LW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .cfg_len_i (cfg_len_i),
    .start_i   (start_i),
    .done_o    (done_o),
    .in_val_i  (in_val_i),
    .in_dat_i  (in_dat_i),
    .in_rdy_o  (in_rdy_o),
    .out_val_o (out_val_o),
    .out_dat_o (out_dat_o),
    .out_rdy_i (out_rdy_i)
  );

  int         testsRun = 0;
  int         testsFailed = 0;
  logic [7:0] payload[$];
  logic [7:0] expQ[$];
  logic [7:0] gotQ[$];
  logic [7:0] refQ[$];
  int         expTotal = 0;
  bit         armed = 1'b0;
  bit         doneSeen = 1'b0;
  int         cyc = 0;
  int         doneDue = -1;
  bit         prevHold = 1'b0;
  logic [7:0] prevDat = 8'h00;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference stream from the format rules: framing, block split, Adler-32 by modulo.
  function automatic void buildModel(input int len);
    int rem;
    int n;
    int pos;
`ifdef ZLIB_WRAP_EN
    int unsigned a;
    int unsigned b;
`endif
    expQ.delete();
`ifdef ZLIB_WRAP_EN
    expQ.push_back(8'h78);
    expQ.push_back(8'h01);
`endif
    rem = len;
    pos = 0;
    do begin
      n = (rem < BLK) ? rem : BLK;
      expQ.push_back((rem == n) ? 8'h01 : 8'h00);
      expQ.push_back(n[7:0]);
      expQ.push_back(n[15:8]);
      expQ.push_back(~n[7:0]);
      expQ.push_back(~n[15:8]);
      for (int i = 0; i < n; i++) expQ.push_back(payload[pos + i]);
      pos += n;
      rem -= n;
    end while (rem > 0);
`ifdef ZLIB_WRAP_EN
    a = 1;
    b = 0;
    for (int i = 0; i < len; i++) begin
      a = (a + 32'(payload[i])) % 65521;
      b = (b + a) % 65521;
    end
    expQ.push_back(8'(b >> 8));
    expQ.push_back(8'(b));
    expQ.push_back(8'(a >> 8));
    expQ.push_back(8'(a));
`endif
    expTotal = expQ.size();
  endfunction

  // Per-cycle compare: byte order, hold during stall, done exactly one cycle after last handshake.
  always @(negedge clk) begin
    cyc++;
    if (armed) begin
      if (prevHold) begin
        checkOutput("hold_val", 32'(out_val_o), 32'd1);
        checkOutput("hold_dat", 32'(out_dat_o), 32'(prevDat));
      end
      if (done_o || cyc == doneDue) begin
        checkOutput("done_pulse", 32'(done_o), 32'(cyc == doneDue));
        if (done_o) doneSeen = 1'b1;
      end
      if (out_val_o && out_rdy_i) begin
        gotQ.push_back(out_dat_o);
        if (expQ.size() == 0) begin
          checkOutput("extra_byte", 32'(gotQ.size()), 32'(expTotal));
        end else begin
          checkOutput("stream_byte", 32'(out_dat_o), 32'(expQ.pop_front()));
          if (expQ.size() == 0) doneDue = cyc + 1;
        end
      end
      prevHold = out_val_o && !out_rdy_i;
      prevDat  = out_dat_o;
    end else begin
      prevHold = 1'b0;
    end
  end

  task automatic applyStimulus(input int len, input bit gaps, input int abortAt);
    int idx = 0;
    int iter = 0;
    bit acc;
    buildModel(len);
    gotQ.delete();
    doneSeen  = 1'b0;
    doneDue   = -1;
    armed     = 1'b1;
    cfg_len_i = LW'(len);
    start_i   = 1'b1;
    @(posedge clk); #1;
    start_i   = 1'b0;
    cfg_len_i = 24'h0ABCDE;
    while (!doneSeen && iter < 20000 && idx != abortAt) begin
      in_val_i  = (idx < len) && (!gaps || $urandom_range(0, 1) == 1);
      in_dat_i  = (idx < len) ? payload[idx] : 8'h00;
      out_rdy_i = !gaps || ($urandom_range(0, 1) == 1);
      if (len >= 8 && iter == 6) begin
        start_i   = 1'b1;
        cfg_len_i = 24'd5;
      end else begin
        start_i = 1'b0;
      end
      @(negedge clk);
      acc = in_val_i && in_rdy_o;
      @(posedge clk); #1;
      if (acc) idx++;
      iter++;
    end
    in_val_i  = 1'b0;
    start_i   = 1'b0;
    out_rdy_i = 1'b1;
    if (abortAt < 0) begin
      checkOutput("done_seen", 32'(doneSeen), 32'd1);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("leftover", 32'(expQ.size()), 32'd0);
      checkOutput("stream_len", 32'(gotQ.size()), 32'(expTotal));
      armed = 1'b0;
    end
  endtask

  // Literals are full zlib streams; raw-deflate builds drop the 2 header and 4 trailer bytes.
  task automatic checkLiteral(input string name, input logic [255:0] bytes, input int n);
    logic [7:0] e[$];
    int first = 0;
    int last = n - 1;
`ifndef ZLIB_WRAP_EN
    first = 2;
    last  = n - 5;
`endif
    for (int i = first; i <= last; i++) e.push_back(bytes[8*(n-1-i) +: 8]);
    checkOutput({name, "_len"}, 32'(gotQ.size()), 32'(e.size()));
    for (int i = 0; i < e.size() && i < gotQ.size(); i++)
      checkOutput(name, 32'(gotQ[i]), 32'(e[i]));
  endtask

  task automatic checkReset();
    checkOutput("rst_out_val", 32'(out_val_o), 32'd0);
    checkOutput("rst_out_dat", 32'(out_dat_o), 32'd0);
    checkOutput("rst_in_rdy", 32'(in_rdy_o), 32'd0);
    checkOutput("rst_done", 32'(done_o), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    checkReset();
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;

    payload.delete();
    applyStimulus(0, 1'b0, -1);
    checkLiteral("len0", 256'({8'h78, 8'h01, 8'h01, 8'h00, 8'h00, 8'hFF, 8'hFF,
                               8'h00, 8'h00, 8'h00, 8'h01}), 11);

    payload = {8'h61, 8'h62, 8'h63};
    applyStimulus(3, 1'b0, -1);
    checkLiteral("abc", 256'({8'h78, 8'h01, 8'h01, 8'h03, 8'h00, 8'hFC, 8'hFF,
                              8'h61, 8'h62, 8'h63, 8'h02, 8'h4D, 8'h01, 8'h27}), 14);

    payload.delete();
    for (int i = 0; i < 10; i++) payload.push_back(8'(i));
    applyStimulus(10, 1'b0, -1);
    checkLiteral("blk3", 256'({8'h78, 8'h01,
                               8'h00, 8'h04, 8'h00, 8'hFB, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h03,
                               8'h00, 8'h04, 8'h00, 8'hFB, 8'hFF, 8'h04, 8'h05, 8'h06, 8'h07,
                               8'h01, 8'h02, 8'h00, 8'hFD, 8'hFF, 8'h08, 8'h09,
                               8'h00, 8'hAF, 8'h00, 8'h2E}), 31);

    applyStimulus(8, 1'b0, -1);

    payload.delete();
    for (int i = 0; i < 1000; i++) payload.push_back(8'($urandom_range(0, 255)));
    applyStimulus(1000, 1'b0, -1);
    refQ = gotQ;
    applyStimulus(1000, 1'b1, -1);
    checkOutput("gap_len", 32'(gotQ.size()), 32'(refQ.size()));
    for (int i = 0; i < refQ.size() && i < gotQ.size(); i++)
      checkOutput("gap_vs_nostall", 32'(gotQ[i]), 32'(refQ[i]));

    payload.delete();
    for (int i = 0; i < 10; i++) payload.push_back(8'(8'hA0 + i));
    applyStimulus(10, 1'b0, 5);
    armed   = 1'b0;
    doneDue = -1;
    expQ.delete();
    rstn = 1'b0;
    #1;
    checkReset();
    @(posedge clk); #2;
    rstn = 1'b1;
    @(posedge clk); #1;

    payload = {8'h61, 8'h62, 8'h63};
    applyStimulus(3, 1'b0, -1);
    checkLiteral("abc_after_rst", 256'({8'h78, 8'h01, 8'h01, 8'h03, 8'h00, 8'hFC, 8'hFF,
                                        8'h61, 8'h62, 8'h63, 8'h02, 8'h4D, 8'h01, 8'h27}), 14);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/zlib_stored.md
# zlib_stored

Packs the filtered PNG scanline byte stream from the filter stage into a zlib stream made of stored (uncompressed, BTYPE=00) deflate blocks, and computes the Adler-32 trailer. It sits directly downstream of the filter stage's output FIFO and feeds the IDAT chunk writer. One `start_i` produces one complete stream of `cfg_len_i` payload bytes.

## Interface
- BLK_MAX, 65535: maximum payload bytes per stored block (1..65535).
- LEN_WD, 24: width of the total payload length.
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- cfg_len_i  in  LEN_WD  total payload bytes (h*(1+row bytes)); sampled on start.
- start_i  in  1  one-cycle start pulse; honoured only in IDLE.
- done_o  out  1  one-cycle pulse after the last stream byte is accepted downstream.
- in_val_i  in  1  payload byte valid (filter FIFO read side).
- in_dat_i  in  8  payload byte.
- in_rdy_o  out  1  payload byte accepted when in_val_i && in_rdy_o.
- out_val_o  out  1  stream byte valid.
- out_dat_o  out  8  stream byte.
- out_rdy_i  in  1  downstream accepts when out_val_o && out_rdy_i.

## Operation
- FSM: IDLE -> HDR0 (0x78) -> HDR1 (0x01) -> BHDR -> LEN0 -> LEN1 -> NLEN0 -> NLEN1 -> DATA -> (BHDR if bytes remain, else ADL0) -> ADL0..ADL3 -> IDLE.
- Block size = min(remaining, BLK_MAX). BHDR byte = 0x01 if this is the last block, else 0x00. LEN little-endian; NLEN = ~LEN.
- cfg_len_i = 0: single final block 01 00 00 FF FF, DATA skipped, Adler 00 00 00 01.
- Adler-32: a=1, b=0 at start; per payload byte a'=a+byte, subtract 65521 if a'>=65521; b'=b+a', subtract 65521 if b'>=65521. 17-bit intermediates, one conditional subtract each. Trailer big-endian: b[15:8], b[7:0], a[15:8], a[7:0].
- Counters: remaining (LEN_WD), in-block (16 bits); both decrement on each accepted payload byte.
- start_i outside IDLE ignored. in_val_i outside DATA ignored (in_rdy_o=0).

## Timing
- Reset: state IDLE, out_val_o=0, out_dat_o=0, in_rdy_o=0, done_o=0, a=1, b=0, counters 0.
- Output is a single register stage: out_dat_o/out_val_o stable while out_val_o && !out_rdy_i.
- in_rdy_o = (state==DATA) && (!out_val_o || out_rdy_i); accepted byte appears on out_dat_o next cycle. Throughput 1 byte/cycle with continuous valid/ready.
- First header byte valid the cycle after start_i.
- Stream overhead: 2 + 5*nblocks + 4 bytes; with no stalls, done_o fires the cycle after the last trailer byte handshake.
- Adler update of the final payload byte completes before ADL0 is loaded. No stall bubble at DATA->BHDR or DATA->ADL0.
- Reset mid-stream: immediate return to reset values; the partial stream is discarded and no done_o is generated.

## Configuration
- ZLIB_WRAP_EN defined: HDR0/HDR1 and ADL0..ADL3 are emitted (zlib stream, RFC 1950).
- Not defined: header and trailer states plus the Adler logic are removed; raw deflate stream (RFC 1951) only. IDLE goes directly to BHDR, and the final DATA state goes to IDLE.

## Structure
- Shared package/defines: zlib header bytes 0x78/0x01, ADLER_MOD=65521, the BTYPE stored code, and the FSM state encodings.
- Sub-module `adler32_acc`: clear, byte valid, byte in; registered a/b out. Compiled only under ZLIB_WRAP_EN.

## Test plan
- cfg_len=0, out_rdy=1 -> 78 01 01 00 00 FF FF 00 00 00 01, then done_o.
- cfg_len=3, payload 61 62 63 -> 78 01 01 03 00 FC FF 61 62 63 02 4D 01 27.
- BLK_MAX=4, cfg_len=10, payload 00..09 -> three blocks: 00 04 00 FB FF ×4 bytes, 00 04 00 FB FF ×4 bytes, 01 02 00 FD FF ×2 bytes; Adler matches the software model.
- Random out_rdy_i (50%) and in_val_i gaps on a 1000-byte payload -> byte-exact match with the zero-stall run; output held stable during stalls.
- rstn asserted in DATA, then a new start with cfg_len=3 -> clean stream as in scenario 2, no stale done_o.
- ZLIB_WRAP_EN undefined, cfg_len=3 -> 01 03 00 FC FF 61 62 63, then done_o.
